pulse_gen_multi: RTL and testbench

//   Parametrised multi-channel pulse/burst generator; successor to single-shot PIO-driven delay/width pulser.

---
 rtl/pulse_gen_multi.sv | 189 ++++++++++++++++++
 tb/tb_pulse_gen_multi.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse/burst generator.
// Each channel latches delay/width/period/count on a start rising edge and then
// runs DELAY -> HIGH -> LOW -> HIGH ... -> IDLE. A count of zero means the channel
// runs continuously until it is aborted. All outputs are registered.
module pulse_gen_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int REP_W  = 16
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
    input  logic [NUM_CH*CNT_W-1:0] cfg_width,
    input  logic [NUM_CH*CNT_W-1:0] cfg_period,
    input  logic [NUM_CH*REP_W-1:0] cfg_count,
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

    // Pulses-remaining counter never wraps below zero.
    function automatic logic [REP_W-1:0] sat_dec(input logic [REP_W-1:0] v);
        if (v == REP_ZERO) begin
            return REP_ZERO;
        end else begin
            return v - REP_ONE;
        end
    endfunction

    logic [NUM_CH-1:0] start_q;

    // Start edge detector; resets to all-ones so a start held through reset cannot fire.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            start_q <= {NUM_CH{1'b1}};
        end else begin
            start_q <= start;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] high_len_q;
        logic [CNT_W-1:0] low_len_q;
        logic [REP_W-1:0] rem_q;
        logic             cont_q;
        logic             pulse_q;
        logic             busy_q;
        logic             done_q;

        logic [CNT_W-1:0] delay_s;
        logic [CNT_W-1:0] width_raw_s;
        logic [CNT_W-1:0] period_raw_s;
        logic [CNT_W-1:0] width_s;
        logic [CNT_W-1:0] low_s;
        logic [REP_W-1:0] count_s;
        logic             trig_s;

        // Slice this channel's config, apply clamps (width>=1, low phase>=1) and detect a trigger.
        always_comb begin
            delay_s      = cfg_delay[i*CNT_W +: CNT_W];
            width_raw_s  = cfg_width[i*CNT_W +: CNT_W];
            period_raw_s = cfg_period[i*CNT_W +: CNT_W];
            count_s      = cfg_count[i*REP_W +: REP_W];
            if (width_raw_s == CNT_ZERO) begin
                width_s = CNT_ONE;
            end else begin
                width_s = width_raw_s;
            end
            // Low time is computed directly so a maximal width cannot overflow width+1.
            if (period_raw_s <= width_s) begin
                low_s = CNT_ONE;
            end else begin
                low_s = period_raw_s - width_s;
            end
            trig_s = start[i] & ~start_q[i] & ~abort[i] & (state_q == ST_IDLE);
        end

        // Channel FSM with registered pulse/busy/done outputs; abort overrides everything.
        always_ff @(posedge clk_clk) begin
            if (!reset_reset_n) begin
                state_q    <= ST_IDLE;
                cnt_q      <= CNT_ZERO;
                high_len_q <= CNT_ZERO;
                low_len_q  <= CNT_ZERO;
                rem_q      <= REP_ZERO;
                cont_q     <= 1'b0;
                pulse_q    <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (abort[i]) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= CNT_ZERO;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (trig_s) begin
                                high_len_q <= width_s;
                                low_len_q  <= low_s;
                                cont_q     <= (count_s == REP_ZERO);
                                busy_q     <= 1'b1;
                                if (delay_s != CNT_ZERO) begin
                                    state_q <= ST_DELAY;
                                    cnt_q   <= delay_s - CNT_ONE;
                                    rem_q   <= count_s;
                                    pulse_q <= 1'b0;
                                end else begin
                                    state_q <= ST_HIGH;
                                    cnt_q   <= width_s - CNT_ONE;
                                    rem_q   <= sat_dec(count_s);
                                    pulse_q <= 1'b1;
                                end
                            end else begin
                                pulse_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end
                        ST_DELAY: begin
                            if (cnt_q == CNT_ZERO) begin
                                state_q <= ST_HIGH;
                                cnt_q   <= high_len_q - CNT_ONE;
                                rem_q   <= sat_dec(rem_q);
                                pulse_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q - CNT_ONE;
                            end
                        end
                        ST_HIGH: begin
                            if (cnt_q == CNT_ZERO) begin
                                pulse_q <= 1'b0;
                                if (!cont_q && (rem_q == REP_ZERO)) begin
                                    // Final pulse: no trailing low phase.
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_LOW;
                                    cnt_q   <= low_len_q - CNT_ONE;
                                end
                            end else begin
                                cnt_q <= cnt_q - CNT_ONE;
                            end
                        end
                        ST_LOW: begin
                            if (cnt_q == CNT_ZERO) begin
                                state_q <= ST_HIGH;
                                cnt_q   <= high_len_q - CNT_ONE;
                                rem_q   <= sat_dec(rem_q);
                                pulse_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q - CNT_ONE;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            cnt_q   <= CNT_ZERO;
                            pulse_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign pulse_out[i] = pulse_q;
        assign busy[i]      = busy_q;
        assign done[i]      = done_q;
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Scoreboard bench for pulse_gen_multi: each accepted trigger expands into a
// timed list of rise/fall/done events computed arithmetically from the
// configuration; a negedge monitor pops and compares them as the DUT shows them.
module tb_pulse_gen_multi;

    localparam int NCH     = 4;
    localparam int CW      = 32;
    localparam int RW      = 16;
    localparam int BIG     = 1000000000;
    localparam int HORIZON = 4000;
    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int t;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       abort;
    logic [NCH*CW-1:0]    cfg_delay;
    logic [NCH*CW-1:0]    cfg_width;
    logic [NCH*CW-1:0]    cfg_period;
    logic [NCH*RW-1:0]    cfg_count;
    logic [NCH-1:0]       pulse_out;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       done;

    pulse_gen_multi #(.NUM_CH(NCH), .CNT_W(CW), .REP_W(RW)) dut (
        .clk_clk       (clk),
        .reset_reset_n (reset_n),
        .start         (start),
        .abort         (abort),
        .cfg_delay     (cfg_delay),
        .cfg_width     (cfg_width),
        .cfg_period    (cfg_period),
        .cfg_count     (cfg_count),
        .pulse_out     (pulse_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ev_t evq[NCH][$];
    int  bs[NCH];
    int  be[NCH];
    int  m_first[NCH];
    int  m_w[NCH];
    int  m_p[NCH];
    int  m_n[NCH];
    int  cfg_d[NCH];
    int  cfg_w[NCH];
    int  cfg_p[NCH];
    int  cfg_n[NCH];
    logic [NCH-1:0] prev_s;
    logic [NCH-1:0] st_v;
    bit  mon_en = 1'b0;

    function automatic bit high_at(input int c, input int t);
        int k;
        if (t < bs[c] || t > be[c] || t < m_first[c]) return 1'b0;
        k = (t - m_first[c]) / m_p[c];
        if (m_n[c] != 0 && k >= m_n[c]) return 1'b0;
        return ((t - m_first[c]) % m_p[c]) < m_w[c];
    endfunction

    task automatic push_ev(input int c, input int kind, input int t);
        ev_t e;
        e.kind = kind;
        e.t    = t;
        evq[c].push_back(e);
    endtask

    task automatic add_burst(input int c, input int tt);
        int w, p, n, first, lim;
        w = (cfg_w[c] == 0) ? 1 : cfg_w[c];
        p = (cfg_p[c] <= w) ? w + 1 : cfg_p[c];
        n = cfg_n[c];
        first = tt + cfg_d[c];
        bs[c] = tt;
        m_first[c] = first;
        m_w[c] = w;
        m_p[c] = p;
        m_n[c] = n;
        if (n == 0) begin
            lim = HORIZON / p + 1;
            for (int k = 0; k < lim; k++) begin
                push_ev(c, EV_RISE, first + k * p);
                push_ev(c, EV_FALL, first + k * p + w);
            end
            be[c] = BIG;
        end else begin
            for (int k = 0; k < n; k++) begin
                push_ev(c, EV_RISE, first + k * p);
                push_ev(c, EV_FALL, first + k * p + w);
            end
            push_ev(c, EV_DONE, first + (n - 1) * p + w);
            be[c] = first + (n - 1) * p + w - 1;
        end
    endtask

    // Abort or reset sampled at edge a: channel idle with outputs low from time a.
    task automatic kill(input int c, input int a);
        bit h;
        if (be[c] >= a - 1) begin
            h = high_at(c, a - 1);
            while (evq[c].size() > 0 && evq[c][evq[c].size()-1].t >= a) begin
                void'(evq[c].pop_back());
            end
            if (h) push_ev(c, EV_FALL, a);
            be[c] = a - 1;
        end
    endtask

    task automatic pack_cfg();
        for (int c = 0; c < NCH; c++) begin
            cfg_delay[c*CW +: CW]  = CW'(cfg_d[c]);
            cfg_width[c*CW +: CW]  = CW'(cfg_w[c]);
            cfg_period[c*CW +: CW] = CW'(cfg_p[c]);
            cfg_count[c*RW +: RW]  = RW'(cfg_n[c]);
        end
    endtask

    task automatic drive(input logic [NCH-1:0] st, input logic [NCH-1:0] ab);
        int tt;
        tt = cyc + 1;
        for (int c = 0; c < NCH; c++) begin
            if (ab[c]) kill(c, tt);
            else if (st[c] && !prev_s[c] && (tt - 1) > be[c]) add_burst(c, tt);
            prev_s[c] = st[c];
        end
        st_v = st;
        start = st;
        abort = ab;
        reset_n = 1'b1;
        pack_cfg();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NCH-1:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NCH; c++) kill(c, cyc + 1);
            prev_s = {NCH{1'b1}};
            st_v = st;
            start = st;
            abort = '0;
            reset_n = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(st_v, '0);
    endtask

    task automatic set_cfg(input int c, input int d, input int w, input int p, input int n);
        cfg_d[c] = d;
        cfg_w[c] = w;
        cfg_p[c] = p;
        cfg_n[c] = n;
    endtask

    task automatic check_out0(input string name);
        checks++;
        if (pulse_out !== 4'b0000 || busy !== 4'b0000 || done !== 4'b0000) begin
            errors++;
            $display("FAIL %s: pulse_out=%b busy=%b done=%b, required all 0", name, pulse_out, busy, done);
        end
    endtask

    task automatic check_ev(input int c, input int kind);
        ev_t e;
        checks++;
        if (evq[c].size() == 0) begin
            errors++;
            $display("FAIL unexpected_ev ch%0d: got kind %0d at t=%0d, required none", c, kind, cyc);
        end else begin
            e = evq[c].pop_front();
            if (e.kind != kind || e.t != cyc) begin
                errors++;
                $display("FAIL event ch%0d: got kind %0d at t=%0d, required kind %0d at t=%0d",
                         c, kind, cyc, e.kind, e.t);
            end
        end
    endtask

    // Monitor: compare observed edges/strobes with the scoreboard and busy with the model window.
    logic [NCH-1:0] prev_p = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < NCH; c++) begin
                while (evq[c].size() > 0 && evq[c][0].t < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_ev ch%0d: kind %0d required at t=%0d, not seen by t=%0d",
                             c, evq[c][0].kind, evq[c][0].t, cyc);
                    void'(evq[c].pop_front());
                end
                if (pulse_out[c] === 1'b1 && prev_p[c] !== 1'b1) check_ev(c, EV_RISE);
                if (pulse_out[c] !== 1'b1 && prev_p[c] === 1'b1) check_ev(c, EV_FALL);
                if (done[c] !== 1'b0) check_ev(c, EV_DONE);
                checks++;
                if (busy[c] !== ((cyc >= bs[c]) && (cyc <= be[c]))) begin
                    errors++;
                    $display("FAIL busy ch%0d t=%0d: got %b, required %b", c, cyc, busy[c],
                             (cyc >= bs[c]) && (cyc <= be[c]));
                end
                prev_p[c] = pulse_out[c];
            end
        end
    end

    initial begin
        int waited;
        logic [NCH-1:0] rs, ra;
        for (int c = 0; c < NCH; c++) begin
            bs[c] = 0;
            be[c] = -1;
            m_first[c] = 0;
            m_w[c] = 1;
            m_p[c] = 2;
            m_n[c] = 0;
            set_cfg(c, 0, 0, 0, 1);
        end
        prev_s = {NCH{1'b1}};
        st_v = '0;
        start = '0;
        abort = '0;
        reset_n = 1'b0;
        pack_cfg();
        repeat (3) @(posedge clk);
        #1;
        check_out0("reset_state");
        mon_en = 1'b1;
        idle_cycles(2);

        // 1: ch0 delay=3 width=2 count=1
        set_cfg(0, 3, 2, 5, 1);
        drive(4'b0001, '0);
        idle_cycles(9);
        // 2: ch1 delay=0 width=3 period=10 count=4
        set_cfg(1, 0, 3, 10, 4);
        drive(4'b0010, '0);
        idle_cycles(38);
        // 3: ch2 continuous square wave, aborted after 7 pulses
        set_cfg(2, 0, 1, 2, 0);
        drive(4'b0100, '0);
        idle_cycles(13);
        drive(4'b0100, 4'b0100);
        idle_cycles(4);
        // 4: ch3 width=0 period=0 count=2 -> clamped
        set_cfg(3, 0, 0, 0, 2);
        drive(4'b1000, '0);
        idle_cycles(6);

        // 5: start held across reset release, then reset mid-burst
        drive(4'b1111, '0);
        do_reset(4'b1111, 2);
        idle_cycles(6);
        drive(4'b0000, '0);
        set_cfg(0, 1, 3, 6, 5);
        drive(4'b0001, '0);
        idle_cycles(6);
        do_reset(4'b0000, 1);
        check_out0("reset_mid_burst");
        idle_cycles(3);

        // 6: all channels together, restart while busy ignored
        set_cfg(0, 2, 2, 5, 3);
        set_cfg(1, 0, 1, 3, 4);
        set_cfg(2, 5, 4, 4, 2);
        set_cfg(3, 1, 2, 9, 1);
        drive(4'b1111, '0);
        idle_cycles(3);
        drive(4'b0000, '0);
        drive(4'b1111, '0);
        idle_cycles(30);
        drive(4'b0000, '0);

        // Random phase: config changes every cycle to exercise latching
        for (int i = 0; i < 600; i++) begin
            rs = st_v;
            ra = '0;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) rs[c] = ~rs[c];
                if ($urandom_range(0, 49) == 0) ra[c] = 1'b1;
                set_cfg(c, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 9)), int'($urandom_range(0, 4)));
            end
            if ($urandom_range(0, 299) == 0) do_reset(rs, 1);
            else drive(rs, ra);
        end

        // Drain: stop continuous channels and let bursts finish (bounded)
        drive('0, 4'b1111);
        waited = 0;
        while (waited < 3000 && (be[0] >= cyc || be[1] >= cyc || be[2] >= cyc || be[3] >= cyc)) begin
            drive('0, '0);
            waited++;
        end
        if (waited >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: channels still busy after %0d cycles", waited);
        end
        idle_cycles(3);
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (evq[c].size() != 0) begin
                errors++;
                $display("FAIL leftover_ev ch%0d: %0d events pending, required 0", c, evq[c].size());
            end
        end
        check_out0("final_idle");
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
